// File: rtl/vid_timing_pkg.sv
// Shared types and default raster timing for the video timing sequencer.
package vid_timing_pkg;

    localparam int POS_W = 9;

    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_FRONT,
        ST_SYNC,
        ST_BACK
    } vstate_e;

    localparam pos_t DEF_H_TOTAL      = 9'd384;
    localparam pos_t DEF_H_ACTIVE     = 9'd256;
    localparam pos_t DEF_H_SYNC_START = 9'd288;
    localparam pos_t DEF_H_SYNC_LEN   = 9'd32;
    localparam pos_t DEF_V_TOTAL      = 9'd262;
    localparam pos_t DEF_V_ACTIVE     = 9'd240;
    localparam pos_t DEF_V_SYNC_START = 9'd244;
    localparam pos_t DEF_V_SYNC_LEN   = 9'd4;

endpackage

// File: rtl/vid_ld_counter.sv
// Loadable up-counter in the '163 style: synchronous clear, load, enable and
// a ripple-carry output that flags the terminal count while enabled.
module vid_ld_counter #(
    parameter int               WIDTH    = 9,
    parameter logic [WIDTH-1:0] TERMINAL = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] nxt_o,
    output logic             rco_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // NOTE: default assignment first, so no path through this block leaves cnt_d unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = d_i;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o   = cnt_q;
    assign nxt_o = cnt_d;
    assign rco_o = en_i && (cnt_q == TERMINAL);

endmodule

// File: rtl/vid_timing_seq.sv
// Video timing sequencer: raster counters, sync/blank decode, line/frame strobes and vblank IRQ.
// Define VID_TIMING_IRQ_EN to build the IRQ register and irq_ack handshake; otherwise irq is 0.
module vid_timing_seq
    import vid_timing_pkg::*;
#(
    parameter pos_t H_TOTAL      = DEF_H_TOTAL,
    parameter pos_t H_ACTIVE     = DEF_H_ACTIVE,
    parameter pos_t H_SYNC_START = DEF_H_SYNC_START,
    parameter pos_t H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter pos_t V_TOTAL      = DEF_V_TOTAL,
    parameter pos_t V_ACTIVE     = DEF_V_ACTIVE,
    parameter pos_t V_SYNC_START = DEF_V_SYNC_START,
    parameter pos_t V_SYNC_LEN   = DEF_V_SYNC_LEN
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pix_en,
    input  logic run,
    output pos_t hpos,
    output pos_t vpos,
    output logic hsync_n,
    output logic vsync_n,
    output logic hblank,
    output logic vblank,
    output logic line_stb,
    output logic frame_stb,
    output logic irq,
    input  logic irq_ack
);

    localparam pos_t H_LAST     = H_TOTAL - pos_t'(1);
    localparam pos_t V_LAST     = V_TOTAL - pos_t'(1);
    localparam pos_t H_SYNC_END = H_SYNC_START + H_SYNC_LEN;
    localparam pos_t V_SYNC_END = V_SYNC_START + V_SYNC_LEN;

    logic    adv;
    pos_t    h_q, h_d, v_q, v_d;
    logic    h_rco, v_rco;
    vstate_e state_q, state_d;
    logic    hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
    logic    hblank_q, hblank_d, vblank_q, vblank_d;
    logic    line_stb_q, line_stb_d, frame_stb_q, frame_stb_d;

    assign adv = pix_en & run;

    vid_ld_counter #(.WIDTH(POS_W), .TERMINAL(H_LAST)) u_hcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (1'b0),
        .ld_i    (h_rco),
        .d_i     (pos_t'(0)),
        .en_i    (adv),
        .q_o     (h_q),
        .nxt_o   (h_d),
        .rco_o   (h_rco)
    );

    vid_ld_counter #(.WIDTH(POS_W), .TERMINAL(V_LAST)) u_vcnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (1'b0),
        .ld_i    (v_rco),
        .d_i     (pos_t'(0)),
        .en_i    (h_rco),
        .q_o     (v_q),
        .nxt_o   (v_d),
        .rco_o   (v_rco)
    );

    // Region changes are keyed to the line wrap and the line number about to be shown.
    always_comb begin
        state_d = state_q;
        if (h_rco) begin
            unique case (state_q)
                ST_ACTIVE: if (v_d == V_ACTIVE)     state_d = (V_SYNC_START == V_ACTIVE) ? ST_SYNC : ST_FRONT;
                ST_FRONT:  if (v_d == V_SYNC_START) state_d = ST_SYNC;
                ST_SYNC:   if (v_d == V_SYNC_END)   state_d = ST_BACK;
                ST_BACK:   if (v_d == '0)           state_d = ST_ACTIVE;
                default:                            state_d = ST_ACTIVE;
            endcase
        end

        hsync_n_d   = !((h_d >= H_SYNC_START) && (h_d < H_SYNC_END));
        hblank_d    = (h_d >= H_ACTIVE);
        vsync_n_d   = (state_d != ST_SYNC);
        vblank_d    = (state_d != ST_ACTIVE);
        line_stb_d  = h_rco;
        frame_stb_d = v_rco;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_ACTIVE;
            hsync_n_q   <= 1'b1;
            vsync_n_q   <= 1'b1;
            hblank_q    <= 1'b0;
            vblank_q    <= 1'b0;
            line_stb_q  <= 1'b0;
            frame_stb_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hsync_n_q   <= hsync_n_d;
            vsync_n_q   <= vsync_n_d;
            hblank_q    <= hblank_d;
            vblank_q    <= vblank_d;
            line_stb_q  <= line_stb_d;
            frame_stb_q <= frame_stb_d;
        end
    end

`ifdef VID_TIMING_IRQ_EN
    logic irq_q, irq_d, irq_set;

    // Set has priority so an ack landing on the entry edge cannot swallow a fresh interrupt.
    assign irq_set = h_rco && (state_q == ST_ACTIVE) && (state_d != ST_ACTIVE);
    assign irq_d   = irq_set | (irq_q & ~irq_ack);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_ack;

    assign unused_irq_ack = irq_ack;
    assign irq            = 1'b0;
`endif

    assign hpos      = h_q;
    assign vpos      = v_q;
    assign hsync_n   = hsync_n_q;
    assign vsync_n   = vsync_n_q;
    assign hblank    = hblank_q;
    assign vblank    = vblank_q;
    assign line_stb  = line_stb_q;
    assign frame_stb = frame_stb_q;

endmodule

// File: doc/vid_timing_seq.md
# vid_timing_seq

Video timing sequencer for the Centipede raster. Drives a 9-bit horizontal and a 9-bit vertical loadable counter, each modelled on the '163 clear/load/enable scheme. From those counters it decodes sync, blanking and line/frame strobes, and raises a handshaked vertical-blank interrupt to the CPU side. It is the single owner of raster position; the playfield, sprite and palette logic consume `hpos`/`vpos` and the blank flags.

## Interface
- `H_TOTAL`, 384: pixels per line.
- `H_ACTIVE`, 256: visible pixels, from `hpos`=0.
- `H_SYNC_START`, 288: first `hpos` with `hsync_n` low.
- `H_SYNC_LEN`, 32: hsync width in pixels.
- `V_TOTAL`, 262: lines per frame.
- `V_ACTIVE`, 240: visible lines, from `vpos`=0.
- `V_SYNC_START`, 244: first `vpos` with `vsync_n` low.
- `V_SYNC_LEN`, 4: vsync width in lines.

Ports:
- `clk`, input, 1: system clock; single clock domain.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `pix_en`, input, 1: pixel clock enable, one `clk` per pixel.
- `run`, input, 1: count enable (enp role); low freezes all counters and outputs.
- `hpos`, output, 9: horizontal position, 0..`H_TOTAL`-1.
- `vpos`, output, 9: vertical position, 0..`V_TOTAL`-1.
- `hsync_n`, `vsync_n`, output, 1 each: active-low syncs.
- `hblank`, `vblank`, output, 1 each: high outside the active area.
- `line_stb`, output, 1: one-`clk` pulse when `hpos` wraps to 0.
- `frame_stb`, output, 1: one-`clk` pulse when `hpos` and `vpos` both wrap to 0.
- `irq`, output, 1: vblank interrupt request, level.
- `irq_ack`, input, 1: single-`clk` acknowledge pulse.

## Operation
- Advance condition: `adv = pix_en & run`.
- Horizontal counter:
  - On `adv`, increments.
  - At `H_TOTAL`-1 (terminal count, rco), synchronously loads 0 instead.
- Vertical counter:
  - Enabled by the horizontal rco & `adv`.
  - At `V_TOTAL`-1, loads 0.
- Vertical FSM, advancing only on a horizontal wrap:
  - ACTIVE: `vpos` < `V_ACTIVE`.
  - FRONT: `V_ACTIVE` ≤ `vpos` < `V_SYNC_START`.
  - SYNC: `V_SYNC_START` ≤ `vpos` < `V_SYNC_START`+`V_SYNC_LEN`.
  - BACK: remainder of the frame.
  - Transitions are ACTIVE→FRONT→SYNC→BACK→ACTIVE. If FRONT is zero length, the FSM goes ACTIVE→SYNC directly.
- Decode:
  - `vblank` is high whenever the FSM is not in ACTIVE.
  - `vsync_n` is low in SYNC.
  - `hblank` is high when `hpos` ≥ `H_ACTIVE`.
  - `hsync_n` is low within the `H_SYNC` window.
- Decodes are computed from next-count values and registered, so they are cycle-aligned with `hpos`/`vpos`.
- IRQ:
  - Sets on the `adv` that enters FRONT (or SYNC).
  - Clears on `irq_ack`.
  - If set and ack occur in the same `clk`, set wins.
  - `irq_ack` while `irq` is low has no effect.
- `run` low: counters, FSM and all outputs hold. Strobes are forced 0. `irq` still clears on ack.

## Timing
- Reset values:
  - `hpos`=0, `vpos`=0, FSM=ACTIVE.
  - `hsync_n`=1, `vsync_n`=1.
  - `hblank`=0, `vblank`=0.
  - `line_stb`=0, `frame_stb`=0, `irq`=0.
- Latency: every output changes on the `clk` edge where `adv`=1, one register stage from inputs.
- Strobes: high for exactly the one `clk` after the wrapping `adv` edge. They are not stretched across `pix_en` gaps.
- `reset_n` asserted mid-line or mid-frame returns all outputs to reset values immediately (asynchronous). The first `adv` after release gives `hpos`=1.
- Arithmetic: 9-bit unsigned. Terminal compares are equality, not overflow.

## Configuration
- `VID_TIMING_IRQ_EN`:
  - Defined: IRQ register and `irq_ack` handshake are present.
  - Undefined: `irq` is tied to 0, `irq_ack` is ignored, and no IRQ register is built.

## Structure
- Package `vid_timing_pkg`:
  - FSM state typedef (ACTIVE/FRONT/SYNC/BACK).
  - Default timing constants.
  - 9-bit position typedef.
- Sub-module `vid_ld_counter`:
  - Parameterised width.
  - Clear, load, enable, terminal-count (rco) ports.
  - Instantiated twice, once horizontal and once vertical.

## Test plan
- Release reset, `pix_en`=1, `run`=1:
  - After 383 `clk`, `hpos`=383.
  - Next `clk`: `hpos`=0, `vpos`=1, `line_stb`=1 for 1 `clk`.
- Full frame: `vblank` rises when `vpos`=240, `hpos`=0.
  - `vsync_n` is low for `vpos` 244..247.
  - `frame_stb` fires after 384×262=100608 `adv`.
- `hsync_n` is low exactly for `hpos` 288..319. `hblank`=1 for `hpos` 256..383.
- `pix_en` toggling every other `clk`: positions advance only on enabled `clk`. `line_stb` width stays 1 `clk`.
- IRQ (with `VID_TIMING_IRQ_EN`):
  - Sets at `vpos`=240.
  - `irq_ack` pulse clears it next `clk`.
  - Ack coincident with set leaves `irq`=1.
- `run` low at `hpos`=100 for 50 `clk`: `hpos` holds 100. Assert `reset_n` mid-frame: all outputs return to reset values within the same `clk`.
